// File: rtl/chip_test_pkg.sv
// Shared types and constants for the chip test sequencer and its debouncer.
package chip_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_DONE,
        ST_SETTLE,
        ST_SHOW,
        ST_RELEASE
    } seq_state_t;

    typedef logic [1:0] result_code_t;

    localparam result_code_t RES_NONE    = 2'b00;
    localparam result_code_t RES_PASS    = 2'b01;
    localparam result_code_t RES_FAIL    = 2'b10;
    localparam result_code_t RES_TIMEOUT = 2'b11;

    localparam int SETTLE_CYCLES = 2;
    localparam int RELEASE_MAX   = 4;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw button and emits a one-cycle pulse on each debounced rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic btn,
    output logic start_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt tracks how many consecutive samples disagree with the accepted level
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            level     <= 1'b0;
            cnt       <= '0;
            start_evt <= 1'b0;
        end else begin
            sync1     <= btn;
            sync2     <= sync1;
            start_evt <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt       <= '0;
                level     <= sync2;
                start_evt <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/chip_test_sequencer.sv
// Launches a chip tester from a debounced button, grades its result, shows it,
// then releases the tester; keeps saturating pass/fail tallies.
module chip_test_sequencer
    import chip_test_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start_btn,
    input  logic         Done,
    input  logic         RSLT,
    output logic         Run,
    output logic         DISP_RSLT,
    output logic         Busy,
    output result_code_t Result_code,
    output logic [7:0]   Pass_count,
    output logic [7:0]   Fail_count
);

    localparam int TM1  = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int TMAX = (TM1 > RELEASE_MAX) ? TM1 : RELEASE_MAX;
    localparam int CW   = $clog2(TMAX + 1);

    seq_state_t    state, state_nx;
    logic [CW-1:0] timer, timer_nx;
    result_code_t  code_nx;
    logic          pass_inc, fail_inc;
    logic          start_evt;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .btn       (Start_btn),
        .start_evt (start_evt)
    );

    // One shared timer; it is zeroed on every state change
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        code_nx  = Result_code;
        pass_inc = 1'b0;
        fail_inc = 1'b0;
        unique case (state)
            ST_IDLE: begin
                timer_nx = '0;
                if (start_evt) state_nx = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                timer_nx = '0;
                state_nx = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (Done) begin
                    state_nx = ST_SETTLE;
                    timer_nx = '0;
                end else if (timer == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_nx = ST_SHOW;
                    timer_nx = '0;
                    code_nx  = RES_TIMEOUT;
                    fail_inc = 1'b1;
                end else begin
                    timer_nx = timer + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (timer == CW'(SETTLE_CYCLES - 1)) begin
                    state_nx = ST_SHOW;
                    timer_nx = '0;
                    code_nx  = RSLT ? RES_PASS : RES_FAIL;
                    pass_inc = RSLT;
                    fail_inc = !RSLT;
                end else begin
                    timer_nx = timer + CW'(1);
                end
            end
            ST_SHOW: begin
                if (timer == CW'(HOLD_CYCLES - 1)) begin
                    state_nx = ST_RELEASE;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + CW'(1);
                end
            end
            ST_RELEASE: begin
                // A timed-out tester never raised Done, so one release cycle suffices
                if (Result_code == RES_TIMEOUT || !Done || timer == CW'(RELEASE_MAX - 1)) begin
                    state_nx = ST_IDLE;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + CW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            Result_code <= RES_NONE;
            Pass_count  <= 8'd0;
            Fail_count  <= 8'd0;
            Run         <= 1'b0;
            DISP_RSLT   <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            Result_code <= code_nx;
            if (pass_inc) Pass_count <= sat_inc(Pass_count);
            if (fail_inc) Fail_count <= sat_inc(Fail_count);
            Run       <= (state_nx == ST_LAUNCH);
            DISP_RSLT <= (state_nx == ST_RELEASE);
            Busy      <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: doc/chip_test_sequencer.md
Name: chip_test_sequencer

Overview:
Downstream controller for the per-chip tester modules (for example the 74194-family checker). It turns a raw front-panel start button into a single-cycle Run pulse and waits for the tester's Done. It then latches the tester's RSLT into a pass/fail/timeout code, holds that code for a display period, and releases the tester back to Halted with DISP_RSLT. It also keeps saturating pass and fail tallies for the front-panel LEDs and hex display.

Parameters:
DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples required before the button level is accepted.
HOLD_CYCLES, 1000, number of cycles the result is held in SHOW before DISP_RSLT is asserted.
TIMEOUT_CYCLES, 4096, maximum number of cycles spent in WAIT_DONE before the test is declared timed out.

Ports:
Clk  input  1  system clock; all logic on the rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Start_btn  input  1  raw, asynchronous start button, active-high.
Done  input  1  Done output from the selected chip tester.
RSLT  input  1  RSLT output from the selected chip tester (1 = pass).
Run  output  1  start pulse to the tester.
DISP_RSLT  output  1  release to the tester, which returns it from Done_s to Halted.
Busy  output  1  high in every state except IDLE.
Result_code  output  2  00 none, 01 pass, 10 fail, 11 timeout.
Pass_count  output  8  saturating count of passed tests.
Fail_count  output  8  saturating count of failed and timed-out tests.

Behaviour:
- Reset (Reset_n low, asynchronous): state IDLE; Run=0, DISP_RSLT=0, Busy=0, Result_code=00, both counts 0; debounce and timers cleared.
- Start_btn path: 2-flop synchronizer feeding the debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES identical consecutive samples.
  - start_evt is a one-cycle pulse on the debounced rising edge.
  - start_evt is ignored outside IDLE and is not queued.
- States: IDLE, LAUNCH, WAIT_DONE, SETTLE, SHOW, RELEASE.
- IDLE
  - Result_code keeps its last value.
  - start_evt -> LAUNCH.
- LAUNCH
  - Run=1 for exactly this one cycle, then WAIT_DONE.
  - Run is never high for more than one cycle, because the tester restarts from Halted on any sampled Run.
- WAIT_DONE
  - Timer counts up from 0.
  - Done=1 -> SETTLE; this takes priority over timeout on the same cycle.
  - Timer reaching TIMEOUT_CYCLES-1 with Done=0 -> Result_code=11, Fail_count+1, SHOW.
- SETTLE
  - Lasts 2 cycles; this covers the tester's one-cycle registered RSLT lag.
  - On the last cycle, sample RSLT: 1 gives Result_code=01 and Pass_count+1; 0 gives Result_code=10 and Fail_count+1. Then SHOW.
- SHOW
  - Hold counter runs from 0 to HOLD_CYCLES-1, then RELEASE.
- RELEASE
  - DISP_RSLT=1 while in this state.
  - Done sampled 0 -> IDLE.
  - After a timeout, DISP_RSLT is held for exactly 1 cycle and the FSM returns to IDLE regardless of Done.
  - If Done is still 1 after 4 cycles -> IDLE anyway (tester stuck); DISP_RSLT drops.
- Counts saturate at 8'hFF; an increment at 255 is discarded.
- Result_code changes only at the SETTLE capture or on timeout. It is not cleared on LAUNCH; the previous result stays visible until the new one is decided.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - Run and DISP_RSLT drop asynchronously.
  - Counts clear.
- Done=1 while in IDLE (stale tester): ignored; no count change.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package chip_test_pkg:
  - seq_state_t enum.
  - result_code_t, with constants RES_NONE, RES_PASS, RES_FAIL, RES_TIMEOUT.
  - Constant SETTLE_CYCLES=2.
  - Constant RELEASE_MAX=4.
- One sub-module, button_debounce:
  - Contains the synchronizer, stable-sample counter, debounced level and rising-edge pulse.
  - Parameterised by DEBOUNCE_CYCLES.
  - Uses the same Clk and Reset_n.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, TIMEOUT_CYCLES=32.
- Bouncing start: Start_btn toggles every 2 cycles for 10 cycles, then held high -> exactly one Run pulse, 6 or 7 cycles after the last edge (synchronizer plus 4 stable samples); Busy=1 from the following cycle.
- Pass flow: a tester model raises Done 20 cycles after Run with RSLT=1 -> Result_code=01 two cycles later; Pass_count=1; DISP_RSLT rises after 8 SHOW cycles and falls the cycle after Done drops; FSM back in IDLE.
- Fail flow: same as the pass flow with RSLT=0 -> Result_code=10; Fail_count=1; Pass_count unchanged.
- Timeout: Done never asserted -> after 32 WAIT_DONE cycles Result_code=11 and Fail_count=1; after SHOW, one DISP_RSLT cycle, then IDLE.
- Saturation and ignored start: preload 255 passes, run one more pass -> Pass_count stays 255; a button press during SHOW produces no second Run.
- Async reset mid-SHOW: Reset_n low for 1 cycle -> Run and DISP_RSLT low immediately, Result_code=00, counts 0, state IDLE.
